// File: rtl/hamming_bit_sequencer.sv
// Streams the XOR of each hash word against its target word, one difference bit
// per cycle, as load/increment strobes for an external 10-bit population counter.
module hamming_bit_sequencer #(
  parameter int WORD_W = 64,
  parameter int WORDS  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [WORD_W-1:0] target_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic              write_o,
  output logic              increment_o,
  output logic [9:0]        primary_register_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CLEAR     = 3'd1;
  localparam logic [2:0] WAIT_WORD = 3'd2;
  localparam logic [2:0] SHIFT     = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  logic [2:0]        state_reg,    state_next;
  logic [WORD_W-1:0] shift_reg,    shift_next;
  logic [BIT_W-1:0]  bit_idx_reg,  bit_idx_next;
  logic [WIDX_W-1:0] word_idx_reg, word_idx_next;

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx_reg;
    word_idx_next = word_idx_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) state_next = CLEAR;
      end
      CLEAR: begin
        word_idx_next = '0;
        state_next    = WAIT_WORD;
      end
      WAIT_WORD: begin
        if (word_valid_i) begin
          shift_next   = word_i ^ target_i;
          bit_idx_next = '0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        shift_next   = shift_reg >> 1;
        bit_idx_next = bit_idx_reg + BIT_W'(1);
        // Last bit of the word leaves this cycle; the counter has it by the next edge.
        if (bit_idx_reg == LAST_BIT) begin
          if (word_idx_reg == LAST_WORD) begin
            state_next = DONE;
          end else begin
            word_idx_next = word_idx_reg + WIDX_W'(1);
            state_next    = WAIT_WORD;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      word_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      word_idx_reg <= word_idx_next;
    end
  end

  // Every output is a pure decode of registered state, so reset clears them at once.
  assign word_ready_o       = (state_reg == WAIT_WORD);
  assign write_o            = (state_reg == CLEAR);
  assign increment_o        = (state_reg == SHIFT);
  assign primary_register_o = {9'b0, (state_reg == SHIFT) & shift_reg[0]};
  assign busy_o             = (state_reg != IDLE);
  assign done_o             = (state_reg == DONE);

endmodule

// File: doc/hamming_bit_sequencer.md
HAMMING_BIT_SEQUENCER -- requirements
Module: hamming_bit_sequencer

Interface
REQ-001 SHALL have parameter WORD_W, default 64, meaning bits per input word.
REQ-002 SHALL have parameter WORDS, default 16, meaning words per hash (1024 bits total).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start_i, input, 1, begins one hash comparison when idle.
REQ-006 SHALL have port word_i, input, WORD_W, hash word; word 0 arrives first.
REQ-007 SHALL have port target_i, input, WORD_W, target word paired with word_i.
REQ-008 SHALL have port word_valid_i, input, 1, word_i/target_i are valid.
REQ-009 SHALL have port word_ready_o, output, 1, block accepts a word this cycle.
REQ-010 SHALL have port write_o, output, 1, load strobe to the downstream bit counter.
REQ-011 SHALL have port increment_o, output, 1, increment strobe to the downstream bit counter.
REQ-012 SHALL have port primary_register_o, output, 10, value fed to the bit counter; bit 0 is the current difference bit.
REQ-013 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done_o, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, CLEAR, WAIT_WORD, SHIFT, DONE.
REQ-016 IDLE: start_i=1 -> CLEAR; otherwise stay; start_i SHALL be ignored in all other states.
REQ-017 CLEAR: write_o=1, primary_register_o=0 for exactly one cycle; word index <- 0; -> WAIT_WORD.
REQ-018 WAIT_WORD: word_ready_o=1; transfer occurs on word_valid_i & word_ready_o; no transfer -> stay, no strobes.
REQ-019 On transfer, shift register SHALL load word_i XOR target_i; bit index <- 0; -> SHIFT.
REQ-020 SHIFT: increment_o=1, primary_register_o = {9'b0, shift[0]}; shift <- shift >> 1; bit index +1 each cycle.
REQ-021 SHIFT SHALL last exactly WORD_W cycles per word, so bit k of a word is presented in its (k+1)th SHIFT cycle.
REQ-022 After the last SHIFT cycle: word index < WORDS-1 -> word index +1, WAIT_WORD; else -> DONE.
REQ-023 DONE: done_o=1 for one cycle; -> IDLE; downstream counter SHALL already hold the final count during this cycle.
REQ-024 word_ready_o SHALL be 0 outside WAIT_WORD; no word is accepted back-to-back with a SHIFT cycle.
REQ-025 write_o and increment_o SHALL never be high together; primary_register_o SHALL be 0 whenever increment_o and write_o are both 0.
REQ-026 Latency with word_valid_i always high: start_i edge to done_o = 1 + WORDS*(1+WORD_W) + 1 cycles (1042 at defaults).
REQ-027 All outputs SHALL be driven from registered state or decoded state only; no combinational path from word_valid_i to any output other than none (word_ready_o depends on state only).
REQ-028 Block SHALL NOT saturate or correct counts; 1024 difference bits wrap the 10-bit counter to 0 by design.

Reset
REQ-029 rst_ni low SHALL asynchronously force IDLE, shift register 0, indices 0, and all outputs 0.
REQ-030 Reset mid-operation SHALL abort with no further strobes; the next start_i SHALL begin with CLEAR.

Verification
REQ-031 All 16 words equal to target -> 1024 increment cycles, every bit0=0; counter reads 0 at done_o.
REQ-032 Word 0 = 64'h1, target 0, rest equal -> single bit0=1, in first SHIFT cycle after start+2; counter reads 1.
REQ-033 Word 5 = 64'hFFFF_FFFF_FFFF_FFFF, target 0, rest equal -> 64 consecutive bit0=1; counter reads 64.
REQ-034 word_valid_i withheld 5 cycles before word 3 -> word_ready_o held 1, no strobes, done_o delayed 5 cycles, count unchanged.
REQ-035 start_i pulsed during SHIFT -> ignored; exactly one CLEAR and one done_o per run.
REQ-036 rst_ni low during word 7 -> all outputs 0 immediately, IDLE; new start_i gives write_o on next cycle and full correct run.
